// File: rtl/jtag_shift_engine.sv
// JTAG shift engine: clocks up to 32 TMS/TDI bit pairs out on TCK at a programmable
// rate through the GPIO pin vector and returns the TDO bits captured on each bit.
module jtag_shift_engine #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [4:0]           cmd_len,
  input  logic [31:0]          cmd_tms,
  input  logic [31:0]          cmd_tdi,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_tdo,
  output logic [3:0]           gpio_o,
  input  logic [3:0]           gpio_i,
  output logic                 busy
);

  localparam int unsigned LEN_W  = 5;
  localparam int unsigned BITS   = 32;
  localparam int unsigned PINS_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [DIV_WIDTH-1:0] div, div_nxt;
  logic [LEN_W-1:0]     len, len_nxt;
  logic [LEN_W-1:0]     idx, idx_nxt;
  logic [BITS-1:0]      tms, tms_nxt;
  logic [BITS-1:0]      tdi, tdi_nxt;
  logic [BITS-1:0]      tdo_nxt;
  logic [PINS_W-1:0]    pins_nxt;
  logic                 valid_nxt;

  // Only TDO is read back; the other pin inputs are don't-care.
  logic unused_pins;
  assign unused_pins = ^gpio_i[2:0];

  // Next-state, datapath and pin decode; the pin vector is computed one cycle ahead.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div;
    len_nxt   = len;
    idx_nxt   = idx;
    tms_nxt   = tms;
    tdi_nxt   = tdi;
    tdo_nxt   = rsp_tdo;
    pins_nxt  = gpio_o;
    valid_nxt = rsp_valid;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = LOW;
          cnt_nxt   = cfg_div;
          div_nxt   = cfg_div;
          len_nxt   = cmd_len;
          tms_nxt   = cmd_tms;
          tdi_nxt   = cmd_tdi;
          idx_nxt   = '0;
          tdo_nxt   = '0;
          pins_nxt  = {1'b0, 1'b0, cmd_tms[0], cmd_tdi[0]};
        end
      end
      LOW: begin
        if (cnt == '0) begin
          // TDO is taken on the last low cycle, ahead of the TCK rise.
          tdo_nxt[idx] = gpio_i[3];
          state_nxt    = HIGH;
          cnt_nxt      = div;
          pins_nxt[2]  = 1'b1;
        end else begin
          cnt_nxt = cnt - DIV_WIDTH'(1);
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          cnt_nxt     = div;
          pins_nxt[2] = 1'b0;
          if (idx == len) begin
            state_nxt = DONE;
            valid_nxt = 1'b1;
          end else begin
            idx_nxt   = idx + LEN_W'(1);
            state_nxt = LOW;
            pins_nxt  = {1'b0, 1'b0, tms[idx_nxt], tdi[idx_nxt]};
          end
        end else begin
          cnt_nxt = cnt - DIV_WIDTH'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div       <= '0;
      len       <= '0;
      idx       <= '0;
      tms       <= '0;
      tdi       <= '0;
      rsp_tdo   <= '0;
      gpio_o    <= '0;
      rsp_valid <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      div       <= div_nxt;
      len       <= len_nxt;
      idx       <= idx_nxt;
      tms       <= tms_nxt;
      tdi       <= tdi_nxt;
      rsp_tdo   <= tdo_nxt;
      gpio_o    <= pins_nxt;
      rsp_valid <= valid_nxt;
      cmd_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/jtag_shift_engine.md
# jtag_shift_engine

Hardware JTAG shift engine that replaces software bit-banging of the JTAG GPIO lines. It accepts a command carrying up to 32 TMS/TDI bit pairs and clocks them out on TCK at a programmable rate. It captures TDO on each bit and returns the captured word. It sits directly upstream of the GPIO-to-JTAG pin mapper: it drives that block's 4-bit `gpio_o` vector and reads back its `gpio_i` vector.

## Interface

Parameters:
- `DIV_WIDTH`, 8: width of the TCK half-period divider.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_div`  in  DIV_WIDTH  TCK half-period, in `clk` cycles minus 1. Sampled at command accept.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  engine idle; a command can be accepted.
- `cmd_len`  in  5  number of bits minus 1 (0..31 gives 1..32 bits).
- `cmd_tms`  in  32  TMS bits; bit 0 is shifted first.
- `cmd_tdi`  in  32  TDI bits; bit 0 is shifted first.
- `rsp_valid`  out  1  captured TDO word is available.
- `rsp_ready`  in  1  response consumed.
- `rsp_tdo`  out  32  captured TDO; bit i belongs to shifted bit i; bits above `cmd_len` are 0.
- `gpio_o`  out  4  pin vector: [0]=TDI, [1]=TMS, [2]=TCK, [3]=0.
- `gpio_i`  in  4  pin vector: [3]=TDO; [2:0] are ignored.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- States are IDLE, LOW, HIGH and DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch `cmd_tms`, `cmd_tdi`, `cmd_len` and `cfg_div`, clear `rsp_tdo` and bit index `i`=0, then go to LOW.
- LOW:
  - Drive `gpio_o` = {0, TCK=0, tms[i], tdi[i]}.
  - Stay for `div`+1 cycles.
  - On the last cycle, sample `gpio_i[3]` into `rsp_tdo[i]` and go to HIGH.
- HIGH:
  - Drive TCK=1, with TMS/TDI unchanged from LOW.
  - Stay for `div`+1 cycles.
  - If `i`==`len`, go to DONE; otherwise `i`++ and go to LOW.
- DONE:
  - Drive TCK=0; TMS/TDI hold the last bit's values.
  - `rsp_valid`=1.
  - On `rsp_ready`, go to IDLE and drop `rsp_valid`.
- TDO is sampled before the TCK rising edge. TDI/TMS change only while TCK is low, which matches JTAG setup/hold requirements.
- In IDLE, TCK=0 and TMS/TDI hold their last driven values (0 after reset).
- `gpio_o` is registered, with no combinational path from inputs. `cmd_ready` and `busy` are decoded from the state register.
- Divider counter: DIV_WIDTH bits, reloaded at every phase entry. `cfg_div`=0 gives TCK = `clk`/2.
- Changes to `cfg_div` or the `cmd_*` inputs during a command have no effect.
- Only one command is in flight; a new command is not accepted until the response is consumed.

## Timing

- Reset (asynchronous, immediate):
  - State=IDLE.
  - `gpio_o`=4'b0000, with TCK forced low at once.
  - `rsp_valid`=0, `rsp_tdo`=0, `busy`=0, `cmd_ready`=1.
- Accept at edge T0. The first LOW cycle (bit 0 on the pins) is T0+1.
- Each half-phase is D=`cfg_div`+1 cycles; each bit takes 2D cycles.
- `rsp_valid` rises 2D·N cycles after the first LOW cycle, where N=`len`+1.
- `rsp_ready` is honoured in the same cycle `rsp_valid` rises. `cmd_ready` is then 1 on the next cycle.
- Back-to-back minimum gap between the last TCK fall and the next command's bit 0 is 2 cycles.
- While `rsp_valid`=1 and `rsp_ready`=0:
  - `rsp_tdo` and `gpio_o` are stable.
  - `cmd_ready`=0.
- Reset asserted mid-command:
  - The command and response are discarded with no `rsp_valid` pulse.
  - The pins go to 0 immediately.

## Test plan

- Reset: with `rst_n`=0, `gpio_o`=0, `cmd_ready`=1, `rsp_valid`=0 and `busy`=0. These values hold for 3 cycles after release.
- Loopback (`gpio_i[3]`=`gpio_o[0]`), `cfg_div`=0, `cmd_len`=4, `cmd_tdi`=0x0A, `cmd_tms`=0x1F:
  - TCK toggles every cycle for 5 periods.
  - TMS is 1 throughout.
  - `rsp_tdo`=0x0000000A.
  - `rsp_valid` rises 10 cycles after the first LOW cycle.
- Loopback, `cfg_div`=3, `cmd_len`=31, `cmd_tdi`=0xDEADBEEF:
  - Each TCK half-period is 4 cycles.
  - `rsp_tdo`=0xDEADBEEF after 256 cycles.
  - TDI never changes while TCK=1.
- Backpressure: hold `rsp_ready`=0 for 20 cycles after `rsp_valid`:
  - `rsp_tdo`, `gpio_o` (TCK=0) and `cmd_ready`=0 are stable.
  - When `rsp_ready`=1, `rsp_valid` drops and `cmd_ready`=1 on the next cycle.
- Config isolation: change `cfg_div` from 1 to 7 mid-command; the half-period stays 2 cycles until the command completes.
- Reset mid-shift: pull `rst_n` low during a HIGH phase of bit 10:
  - `gpio_o` goes to 0 asynchronously.
  - After release, `cmd_ready`=1, `rsp_valid` is never asserted, and the next command completes correctly.
